// File: rtl/change_disp_ctrl.sv
// Change dispenser controller: converts the owed amount to BCD, requests coins, and drives a scanned 7-segment display.
// Optional macro CHANGE_DISP_BLINK_EN blinks the whole display while coins are being dispensed.
module change_disp_ctrl #(
  parameter int AMT_W      = 8,
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 1000,
  parameter int COIN_VAL   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  amt_valid,
  output logic                  amt_ready,
  input  logic [AMT_W-1:0]      amt,
  input  logic                  coin_ack,
  output logic                  coin_req,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(AMT_W + 1);
  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [31:0]      MAX_VAL = 32'(10 ** NUM_DIGITS - 1);
  localparam logic [AMT_W-1:0] COIN    = AMT_W'(COIN_VAL);
  localparam logic [6:0]       SEG_BLANK = 7'h7F;
  localparam logic [6:0]       SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, CONVERT, DISPENSE, DONE} state_t;

  state_t state_q, state_d;

  logic [AMT_W-1:0]       remain;
  logic [AMT_W-1:0]       conv_sh;
  logic [BCD_W-1:0]       bcd_acc;
  logic [CNT_W-1:0]       conv_cnt;
  logic [BCD_W-1:0]       disp_bcd;
  logic                   ovf_q;
  logic [BCD_W+AMT_W-1:0] dd_shift;
  logic                   accept, ack_take, conv_last;

  logic [DIV_W-1:0]       div_cnt;
  logic [DIG_W-1:0]       digit;
  logic                   scan_on;
  logic                   scan_tick;
  logic                   blink_off;
  logic [NUM_DIGITS-1:0]  lead_zero;
  logic [3:0]             cur_bcd;

  function automatic logic [AMT_W-1:0] sat_sub_coin(input logic [AMT_W-1:0] a);
    return (a > COIN) ? (a - COIN) : '0;
  endfunction

  // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    amt_ready = 1'b0;
    coin_req  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    accept    = 1'b0;
    ack_take  = 1'b0;
    conv_last = 1'b0;
    case (state_q)
      IDLE: begin
        amt_ready = 1'b1;
        busy      = 1'b0;
        if (amt_valid) begin
          accept  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        if (conv_cnt == CNT_W'(AMT_W - 1)) begin
          conv_last = 1'b1;
          state_d   = (remain != '0) ? DISPENSE : DONE;
        end
      end
      DISPENSE: begin
        coin_req = 1'b1;
        if (coin_ack) begin
          ack_take = 1'b1;
          state_d  = CONVERT;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dd_shift = {bcd_adjust(bcd_acc), conv_sh} << 1;

  // Conversion datapath: the shifter is seeded whenever a new remain value is taken,
  // and the display register only changes on the final conversion step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain   <= '0;
      conv_sh  <= '0;
      bcd_acc  <= '0;
      conv_cnt <= '0;
      disp_bcd <= '0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      remain   <= amt;
      conv_sh  <= amt;
      bcd_acc  <= '0;
      conv_cnt <= '0;
    end else if (ack_take) begin
      remain   <= sat_sub_coin(remain);
      conv_sh  <= sat_sub_coin(remain);
      bcd_acc  <= '0;
      conv_cnt <= '0;
    end else if (state_q == CONVERT) begin
      conv_sh  <= dd_shift[AMT_W-1:0];
      bcd_acc  <= dd_shift[BCD_W+AMT_W-1:AMT_W];
      conv_cnt <= conv_cnt + CNT_W'(1);
      if (conv_last) begin
        disp_bcd <= dd_shift[BCD_W+AMT_W-1:AMT_W];
        ovf_q    <= (32'(remain) > MAX_VAL);
      end
    end
  end

  assign ovf       = ovf_q;
  assign scan_tick = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Digit scan: no digit is enabled until the first tick after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      digit   <= '0;
      scan_on <= 1'b0;
    end else if (scan_tick) begin
      div_cnt <= '0;
      scan_on <= 1'b1;
      if (scan_on) digit <= (digit == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit + DIG_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

`ifdef CHANGE_DISP_BLINK_EN
  logic [6:0] blink_cnt;

  // Counts full scan periods; bit 6 toggles every 64 of them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) blink_cnt <= '0;
    else if (scan_tick && scan_on && (digit == DIG_W'(NUM_DIGITS - 1))) blink_cnt <= blink_cnt + 7'd1;
  end

  assign blink_off = (state_q == DISPENSE) && blink_cnt[6];
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    logic above;
    lead_zero = '0;
    above     = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      above        = above && (disp_bcd[4*i +: 4] == 4'd0);
      lead_zero[i] = above;
    end
  end

  assign cur_bcd = disp_bcd[4*int'(digit) +: 4];

  always_comb begin
    an  = '1;
    seg = SEG_BLANK;
    if (scan_on) begin
      an[digit] = 1'b0;
      if (blink_off)             seg = SEG_BLANK;
      else if (ovf_q)            seg = SEG_DASH;
      else if (lead_zero[digit]) seg = SEG_BLANK;
      else                       seg = seg_decode(cur_bcd);
    end
  end

endmodule

// File: tb/tb_change_disp_ctrl.sv
// Directed bench for change_disp_ctrl: a 3-digit and a 2-digit instance, table-driven transactions plus corner sequences.
`timescale 1ns/1ps
module tb_change_disp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid3, ack3, valid2, ack2;
  logic [7:0] amt3, amt2;
  logic       rdy3, req3, busy3, done3, ovf3;
  logic       rdy2, req2, busy2, done2, ovf2;
  logic [6:0] seg3, seg2;
  logic [2:0] an3;
  logic [1:0] an2;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt3 = 0;
  int done_cnt2 = 0;

  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct {
    logic [7:0]  amt;
    int          acks;
    logic [20:0] first;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  change_disp_ctrl #(.AMT_W(8), .NUM_DIGITS(3), .SCAN_DIV(2), .COIN_VAL(5)) u_dut3 (
    .clk(clk), .rst(rst), .amt_valid(valid3), .amt_ready(rdy3), .amt(amt3),
    .coin_ack(ack3), .coin_req(req3), .seg(seg3), .an(an3),
    .busy(busy3), .done(done3), .ovf(ovf3)
  );

  change_disp_ctrl #(.AMT_W(8), .NUM_DIGITS(2), .SCAN_DIV(2), .COIN_VAL(5)) u_dut2 (
    .clk(clk), .rst(rst), .amt_valid(valid2), .amt_ready(rdy2), .amt(amt2),
    .coin_ack(ack2), .coin_req(req2), .seg(seg2), .an(an2),
    .busy(busy2), .done(done2), .ovf(ovf2)
  );

  always @(negedge clk) begin
    if (done3 === 1'b1) done_cnt3++;
    if (done2 === 1'b1) done_cnt2++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference display: digit i at bits [7i+:7], unused digit slots left 0.
  function automatic logic [20:0] exp_disp(input int v, input int nd);
    logic [20:0] d;
    int p;
    d = '0;
    p = 1;
    for (int i = 0; i < nd; i++) begin
      if (i > 0 && v < p) d[7*i +: 7] = 7'h7F;
      else                d[7*i +: 7] = GLYPH[(v / p) % 10];
      p = p * 10;
    end
    if (v >= p) for (int i = 0; i < nd; i++) d[7*i +: 7] = 7'h3F;
    return d;
  endfunction

  task automatic capture(input bit two, output logic [20:0] d);
    logic [2:0] a;
    logic [6:0] s;
    bit bad;
    d   = '0;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a = two ? {1'b1, an2} : an3;
      s = two ? seg2 : seg3;
      if (!$onehot(~a)) bad = 1'b1;
      for (int i = 0; i < 3; i++) if (a[i] == 1'b0) d[7*i +: 7] = s;
    end
    check("an_one_low", 32'(bad), 32'd0);
  endtask

  task automatic accept(input bit two, input logic [7:0] a);
    @(negedge clk);
    check("amt_ready_idle", 32'(two ? rdy2 : rdy3), 32'd1);
    if (two) begin valid2 = 1'b1; amt2 = a; end
    else     begin valid3 = 1'b1; amt3 = a; end
    @(negedge clk);
    valid2 = 1'b0;
    valid3 = 1'b0;
    check("busy_convert", 32'(two ? busy2 : busy3), 32'd1);
    repeat (7) @(negedge clk);
    check("coin_req_during_convert", 32'(two ? req2 : req3), 32'd0);
    @(negedge clk);
  endtask

  task automatic ack_step(input bit two, input int prev, input int next, input int nd);
    logic [20:0] d;
    if (two) ack2 = 1'b1;
    else     ack3 = 1'b1;
    @(negedge clk);
    ack2 = 1'b0;
    ack3 = 1'b0;
    capture(two, d);
    check("disp_hold_convert", 32'(d), 32'(exp_disp(prev, nd)));
    repeat (2) @(negedge clk);
    capture(two, d);
    check("disp_after_ack", 32'(d), 32'(exp_disp(next, nd)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [20:0] d;
    int r, nx, dc;

    vecs[0] = '{amt: 8'd25,  acks: 5,  first: {7'h7F, 7'h24, 7'h12}};
    vecs[1] = '{amt: 8'd7,   acks: 2,  first: {7'h7F, 7'h7F, 7'h78}};
    vecs[2] = '{amt: 8'd0,   acks: 0,  first: {7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{amt: 8'd100, acks: 20, first: {7'h79, 7'h40, 7'h40}};
    vecs[4] = '{amt: 8'd255, acks: 51, first: {7'h24, 7'h12, 7'h12}};

    rst = 1'b1;
    valid3 = 1'b0; ack3 = 1'b0; amt3 = '0;
    valid2 = 1'b0; ack2 = 1'b0; amt2 = '0;
    #3;
    check("rst_seg", 32'(seg3), 32'h7F);
    check("rst_an", 32'(an3), 32'h7);
    check("rst_coin_req", 32'(req3), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_ovf", 32'(ovf3), 32'd0);
    check("rst_amt_ready", 32'(rdy3), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("an_after_release", 32'(an3), 32'h7);
    @(negedge clk);
    check("an_before_tick", 32'(an3), 32'h7);
    @(negedge clk);
    check("an_first_tick", 32'(an3), 32'h6);
    check("seg_zero_first_tick", 32'(seg3), 32'h40);

    for (int t = 0; t < 5; t++) begin
      dc = done_cnt3;
      accept(1'b0, vecs[t].amt);
      check("coin_req_after_convert", 32'(req3), 32'(vecs[t].amt != 8'd0));
      capture(1'b0, d);
      check("disp_first", 32'(d), 32'(vecs[t].first));
      r = int'(vecs[t].amt);
      for (int k = 0; k < vecs[t].acks; k++) begin
        nx = (r > 5) ? r - 5 : 0;
        ack_step(1'b0, r, nx, 3);
        r = nx;
      end
      check("busy_end", 32'(busy3), 32'd0);
      check("amt_ready_end", 32'(rdy3), 32'd1);
      check("done_pulses", 32'(done_cnt3 - dc), 32'd1);
    end

    // coin_ack during CONVERT is dropped; coin_ack in the first DISPENSE cycle is taken
    dc = done_cnt3;
    @(negedge clk);
    valid3 = 1'b1; amt3 = 8'd12;
    @(negedge clk);
    valid3 = 1'b0;
    repeat (7) @(negedge clk);
    ack3 = 1'b1;
    @(negedge clk);
    ack3 = 1'b0;
    check("ack_in_convert_ignored", 32'(req3), 32'd1);
    ack3 = 1'b1;
    @(negedge clk);
    ack3 = 1'b0;
    check("ack_on_entry_taken", 32'(req3), 32'd0);
    repeat (8) @(negedge clk);
    capture(1'b0, d);
    check("disp_7_after_entry_ack", 32'(d), 32'({7'h7F, 7'h7F, 7'h78}));
    valid3 = 1'b1; amt3 = 8'd99;
    #1;
    check("amt_ready_dispense", 32'(rdy3), 32'd0);
    @(negedge clk);
    valid3 = 1'b0;
    check("valid_ignored_dispense", 32'(req3), 32'd1);
    ack_step(1'b0, 7, 2, 3);
    ack_step(1'b0, 2, 0, 3);
    check("seq_done_pulses", 32'(done_cnt3 - dc), 32'd1);
    check("seq_amt_ready", 32'(rdy3), 32'd1);

    // Two-digit overflow: 150 shows dashes until remain drops to 95
    accept(1'b1, 8'd150);
    check("ovf_set", 32'(ovf2), 32'd1);
    capture(1'b1, d);
    check("disp_dashes", 32'(d), 32'({7'h00, 7'h3F, 7'h3F}));
    r = 150;
    for (int k = 0; k < 11; k++) begin
      ack_step(1'b1, r, r - 5, 2);
      r = r - 5;
    end
    check("ovf_clear", 32'(ovf2), 32'd0);
    check("ovf_dispensing", 32'(req2), 32'd1);

    // Reset in the middle of DISPENSE abandons both transactions
    accept(1'b0, 8'd40);
    ack_step(1'b0, 40, 35, 3);
    dc = done_cnt3;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_coin_req", 32'(req3), 32'd0);
    check("midrst_busy", 32'(busy3), 32'd0);
    check("midrst_seg", 32'(seg3), 32'h7F);
    check("midrst_an", 32'(an3), 32'h7);
    check("midrst_amt_ready", 32'(rdy3), 32'd1);
    check("midrst_busy2", 32'(busy2), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ack3 = 1'b1;
    @(negedge clk);
    ack3 = 1'b0;
    check("post_rst_ack_busy", 32'(busy3), 32'd0);
    check("post_rst_ack_req", 32'(req3), 32'd0);
    @(negedge clk);
    check("post_rst_an", 32'(an3), 32'h6);
    check("post_rst_seg_zero", 32'(seg3), 32'h40);
    repeat (3) @(negedge clk);
    check("post_rst_no_done", 32'(done_cnt3 - dc), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
